decode_stage: RTL

- Parametrised, pipelined successor to the combinational decoder.
- Buffers fetched instructions in an internal instruction queue and decodes the queue head.
- Reads the register file, with same-cycle writeback bypass, and registers the result into an output slot.
- valid/ready handshake on both sides; flush support; sign-extended immediates. Sits between fetch and execute.

---
 rtl/decode_stage_if.sv | 51 +++++
 rtl/decode_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-side, register-file, writeback and execute-side signals of decode_stage.
// The decode stage connects through the slave modport; its environment uses master.
interface decode_stage_if #(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned L2_REG_FILE_SIZE = 5
);
    localparam int unsigned INSTR_SIZE      = 32;
    localparam int unsigned INSTR_CODE_SIZE = 6;
    localparam int unsigned B_IMM_SIZE      = 13;
    localparam int unsigned CNT_W           = $clog2(DEPTH + 1);

    logic                        i_flush;
    logic                        i_valid;
    logic                        o_ready;
    logic [INSTR_SIZE-1:0]       i_instruction;
    logic [WORD_SIZE-1:0]        i_instruction_address;
    logic [L2_REG_FILE_SIZE-1:0] o_read_gpr_A_sel;
    logic [WORD_SIZE-1:0]        i_read_gpr_A_data;
    logic [L2_REG_FILE_SIZE-1:0] o_read_gpr_B_sel;
    logic [WORD_SIZE-1:0]        i_read_gpr_B_data;
    logic                        i_wb_en;
    logic [L2_REG_FILE_SIZE-1:0] i_wb_addr;
    logic [WORD_SIZE-1:0]        i_wb_data;
    logic                        o_valid;
    logic                        i_out_ready;
    logic [INSTR_CODE_SIZE-1:0]  o_decoded_instruction;
    logic [WORD_SIZE-1:0]        o_instruction_address;
    logic [WORD_SIZE-1:0]        o_imm_1;
    logic [WORD_SIZE-1:0]        o_imm_2;
    logic [B_IMM_SIZE-1:0]       o_imm_3_or_dest_addr;
    logic [CNT_W-1:0]            o_count;

    modport slave (
        input  i_flush, i_valid, i_instruction, i_instruction_address,
               i_read_gpr_A_data, i_read_gpr_B_data, i_wb_en, i_wb_addr, i_wb_data,
               i_out_ready,
        output o_ready, o_read_gpr_A_sel, o_read_gpr_B_sel, o_valid,
               o_decoded_instruction, o_instruction_address, o_imm_1, o_imm_2,
               o_imm_3_or_dest_addr, o_count
    );

    modport master (
        output i_flush, i_valid, i_instruction, i_instruction_address,
               i_read_gpr_A_data, i_read_gpr_B_data, i_wb_en, i_wb_addr, i_wb_data,
               i_out_ready,
        input  o_ready, o_read_gpr_A_sel, o_read_gpr_B_sel, o_valid,
               o_decoded_instruction, o_instruction_address, o_imm_1, o_imm_2,
               o_imm_3_or_dest_addr, o_count
    );
endinterface

// File: rtl/decode_stage.sv
// Pipelined RV32 decode stage: instruction queue, head decode, regfile read with
// writeback bypass, registered output slot. Define DECODE_STAGE_RV32M_EN to decode RV32M.
module decode_stage #(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned L2_REG_FILE_SIZE = 5,
    parameter int unsigned SIGN_EXTEND      = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    decode_stage_if.slave bus
);
    localparam int unsigned INSTR_SIZE      = 32;
    localparam int unsigned INSTR_CODE_SIZE = 6;
    localparam int unsigned B_IMM_SIZE      = 13;
    localparam int unsigned PTR_W           = $clog2(DEPTH);
    localparam int unsigned CNT_W           = $clog2(DEPTH + 1);

    typedef logic [INSTR_CODE_SIZE-1:0] code_t;
    localparam code_t INSTR_CODE_LUI   = 6'd0,  INSTR_CODE_AUIPC  = 6'd1,  INSTR_CODE_JAL    = 6'd2;
    localparam code_t INSTR_CODE_JALR  = 6'd3,  INSTR_CODE_BEQ    = 6'd4,  INSTR_CODE_BNE    = 6'd5;
    localparam code_t INSTR_CODE_BLT   = 6'd6,  INSTR_CODE_BGE    = 6'd7,  INSTR_CODE_BLTU   = 6'd8;
    localparam code_t INSTR_CODE_BGEU  = 6'd9,  INSTR_CODE_LB     = 6'd10, INSTR_CODE_LH     = 6'd11;
    localparam code_t INSTR_CODE_LW    = 6'd12, INSTR_CODE_LBU    = 6'd13, INSTR_CODE_LHU    = 6'd14;
    localparam code_t INSTR_CODE_SB    = 6'd15, INSTR_CODE_SH     = 6'd16, INSTR_CODE_SW     = 6'd17;
    localparam code_t INSTR_CODE_ADDI  = 6'd18, INSTR_CODE_SLTI   = 6'd19, INSTR_CODE_SLTIU  = 6'd20;
    localparam code_t INSTR_CODE_XORI  = 6'd21, INSTR_CODE_ORI    = 6'd22, INSTR_CODE_ANDI   = 6'd23;
    localparam code_t INSTR_CODE_SLLI  = 6'd24, INSTR_CODE_SRLI   = 6'd25, INSTR_CODE_SRAI   = 6'd26;
    localparam code_t INSTR_CODE_ADD   = 6'd27, INSTR_CODE_SUB    = 6'd28, INSTR_CODE_SLL    = 6'd29;
    localparam code_t INSTR_CODE_SLT   = 6'd30, INSTR_CODE_SLTU   = 6'd31, INSTR_CODE_XOR    = 6'd32;
    localparam code_t INSTR_CODE_SRL   = 6'd33, INSTR_CODE_SRA    = 6'd34, INSTR_CODE_OR     = 6'd35;
    localparam code_t INSTR_CODE_AND   = 6'd36, INSTR_CODE_FENCE  = 6'd37, INSTR_CODE_ECALL  = 6'd38;
    localparam code_t INSTR_CODE_EBREAK = 6'd39, INSTR_CODE_MUL   = 6'd40, INSTR_CODE_MULH   = 6'd41;
    localparam code_t INSTR_CODE_MULHSU = 6'd42, INSTR_CODE_MULHU = 6'd43, INSTR_CODE_DIV    = 6'd44;
    localparam code_t INSTR_CODE_DIVU  = 6'd45, INSTR_CODE_REM    = 6'd46, INSTR_CODE_REMU   = 6'd47;
    localparam code_t INSTR_CODE_INVALID = 6'd63;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [WORD_SIZE-1:0]  addr;
    } entry_t;

    typedef enum logic [2:0] {FMT_NONE, FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R} fmt_e;

    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    code_t                 code_q, code_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d, imm1_q, imm1_d, imm2_q, imm2_d;
    logic [B_IMM_SIZE-1:0] imm3_q, imm3_d;

    logic                  full, head_present, push, load, pop, sx, use_a, use_b;
    entry_t                head;
    logic [INSTR_SIZE-1:0] ins;
    code_t                 dec_code;
    fmt_e                  fmt;
    logic [L2_REG_FILE_SIZE-1:0] sel_a, sel_b;
    logic [WORD_SIZE-1:0]  opnd1_imm, opnd2_imm, rf_a, rf_b, opnd1, opnd2;
    logic [B_IMM_SIZE-1:0] dec_imm3;

    function automatic logic [WORD_SIZE-1:0] widen(input logic [31:0] v, input logic s);
        logic [WORD_SIZE-1:0] r;
        r       = {WORD_SIZE{s}};
        r[31:0] = v;
        return r;
    endfunction

    assign full         = (count_q == CNT_W'(DEPTH));
    assign head_present = (count_q != '0);
    assign push         = bus.i_valid && !full && !bus.i_flush;
    assign load         = head_present && (!valid_q || bus.i_out_ready);
    assign pop          = load && !bus.i_flush;
    assign head         = mem_q[rd_ptr_q];
    assign ins          = head.instr;
    assign sx           = (SIGN_EXTEND != 0) && ins[31];

    // Instruction class and internal code of the queue head.
    always_comb begin
        dec_code = INSTR_CODE_INVALID;
        fmt      = FMT_NONE;
        case (ins[6:0])
            7'b0110111: begin dec_code = INSTR_CODE_LUI;   fmt = FMT_U; end
            7'b0010111: begin dec_code = INSTR_CODE_AUIPC; fmt = FMT_U; end
            7'b1101111: begin dec_code = INSTR_CODE_JAL;   fmt = FMT_J; end
            7'b1100111: begin
                fmt = FMT_I;
                if (ins[14:12] == 3'b000) dec_code = INSTR_CODE_JALR;
            end
            7'b1100011: begin
                fmt = FMT_B;
                case (ins[14:12])
                    3'b000:  dec_code = INSTR_CODE_BEQ;
                    3'b001:  dec_code = INSTR_CODE_BNE;
                    3'b100:  dec_code = INSTR_CODE_BLT;
                    3'b101:  dec_code = INSTR_CODE_BGE;
                    3'b110:  dec_code = INSTR_CODE_BLTU;
                    3'b111:  dec_code = INSTR_CODE_BGEU;
                    default: dec_code = INSTR_CODE_INVALID;
                endcase
            end
            7'b0000011: begin
                fmt = FMT_I;
                case (ins[14:12])
                    3'b000:  dec_code = INSTR_CODE_LB;
                    3'b001:  dec_code = INSTR_CODE_LH;
                    3'b010:  dec_code = INSTR_CODE_LW;
                    3'b100:  dec_code = INSTR_CODE_LBU;
                    3'b101:  dec_code = INSTR_CODE_LHU;
                    default: dec_code = INSTR_CODE_INVALID;
                endcase
            end
            7'b0100011: begin
                fmt = FMT_S;
                case (ins[14:12])
                    3'b000:  dec_code = INSTR_CODE_SB;
                    3'b001:  dec_code = INSTR_CODE_SH;
                    3'b010:  dec_code = INSTR_CODE_SW;
                    default: dec_code = INSTR_CODE_INVALID;
                endcase
            end
            7'b0010011: begin
                fmt = FMT_I;
                case (ins[14:12])
                    3'b000:  dec_code = INSTR_CODE_ADDI;
                    3'b010:  dec_code = INSTR_CODE_SLTI;
                    3'b011:  dec_code = INSTR_CODE_SLTIU;
                    3'b100:  dec_code = INSTR_CODE_XORI;
                    3'b110:  dec_code = INSTR_CODE_ORI;
                    3'b111:  dec_code = INSTR_CODE_ANDI;
                    3'b001: begin
                        fmt = FMT_SH;
                        if (ins[31:25] == 7'b0000000) dec_code = INSTR_CODE_SLLI;
                    end
                    default: begin
                        fmt = FMT_SH;
                        if (ins[31:25] == 7'b0000000)      dec_code = INSTR_CODE_SRLI;
                        else if (ins[31:25] == 7'b0100000) dec_code = INSTR_CODE_SRAI;
                    end
                endcase
            end
            7'b0110011: begin
                fmt = FMT_R;
                case (ins[31:25])
                    7'b0000000: begin
                        case (ins[14:12])
                            3'b000:  dec_code = INSTR_CODE_ADD;
                            3'b001:  dec_code = INSTR_CODE_SLL;
                            3'b010:  dec_code = INSTR_CODE_SLT;
                            3'b011:  dec_code = INSTR_CODE_SLTU;
                            3'b100:  dec_code = INSTR_CODE_XOR;
                            3'b101:  dec_code = INSTR_CODE_SRL;
                            3'b110:  dec_code = INSTR_CODE_OR;
                            default: dec_code = INSTR_CODE_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (ins[14:12] == 3'b000)      dec_code = INSTR_CODE_SUB;
                        else if (ins[14:12] == 3'b101) dec_code = INSTR_CODE_SRA;
                    end
`ifdef DECODE_STAGE_RV32M_EN
                    7'b0000001: begin
                        case (ins[14:12])
                            3'b000:  dec_code = INSTR_CODE_MUL;
                            3'b001:  dec_code = INSTR_CODE_MULH;
                            3'b010:  dec_code = INSTR_CODE_MULHSU;
                            3'b011:  dec_code = INSTR_CODE_MULHU;
                            3'b100:  dec_code = INSTR_CODE_DIV;
                            3'b101:  dec_code = INSTR_CODE_DIVU;
                            3'b110:  dec_code = INSTR_CODE_REM;
                            default: dec_code = INSTR_CODE_REMU;
                        endcase
                    end
`endif
                    default: dec_code = INSTR_CODE_INVALID;
                endcase
            end
            7'b0001111: if (ins[14:12] == 3'b000) dec_code = INSTR_CODE_FENCE;
            7'b1110011: begin
                if (ins == 32'h0000_0073)      dec_code = INSTR_CODE_ECALL;
                else if (ins == 32'h0010_0073) dec_code = INSTR_CODE_EBREAK;
            end
            default: dec_code = INSTR_CODE_INVALID;
        endcase
        // Invalid encodings and an empty queue read no registers and carry no operands.
        if (dec_code == INSTR_CODE_INVALID || !head_present) fmt = FMT_NONE;
    end

    // Register selects, immediates and the bypassed operand values.
    always_comb begin
        use_a     = 1'b0;
        use_b     = 1'b0;
        opnd1_imm = '0;
        opnd2_imm = '0;
        dec_imm3  = '0;
        case (fmt)
            FMT_U:  begin opnd1_imm = widen({ins[31:12], 12'b0}, sx); dec_imm3 = B_IMM_SIZE'(ins[11:7]); end
            FMT_J:  begin
                opnd1_imm = widen({{11{sx}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, sx);
                dec_imm3  = B_IMM_SIZE'(ins[11:7]);
            end
            FMT_I:  begin use_a = 1'b1; opnd2_imm = widen({{20{sx}}, ins[31:20]}, sx); dec_imm3 = B_IMM_SIZE'(ins[11:7]); end
            FMT_SH: begin use_a = 1'b1; opnd2_imm = widen({27'b0, ins[24:20]}, 1'b0); dec_imm3 = B_IMM_SIZE'(ins[11:7]); end
            FMT_B:  begin use_a = 1'b1; use_b = 1'b1; dec_imm3 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
            FMT_S:  begin use_a = 1'b1; use_b = 1'b1; dec_imm3 = {sx, ins[31:25], ins[11:7]}; end
            FMT_R:  begin use_a = 1'b1; use_b = 1'b1; dec_imm3 = B_IMM_SIZE'(ins[11:7]); end
            default: ;
        endcase
        sel_a = use_a ? L2_REG_FILE_SIZE'(ins[19:15]) : '0;
        sel_b = use_b ? L2_REG_FILE_SIZE'(ins[24:20]) : '0;
        if (sel_a == '0)                          rf_a = '0;
        else if (bus.i_wb_en && bus.i_wb_addr == sel_a) rf_a = bus.i_wb_data;
        else                                      rf_a = bus.i_read_gpr_A_data;
        if (sel_b == '0)                          rf_b = '0;
        else if (bus.i_wb_en && bus.i_wb_addr == sel_b) rf_b = bus.i_wb_data;
        else                                      rf_b = bus.i_read_gpr_B_data;
        opnd1 = use_a ? rf_a : opnd1_imm;
        opnd2 = use_b ? rf_b : opnd2_imm;
    end

    // Queue and output-slot next state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        code_d   = code_q;
        addr_d   = addr_q;
        imm1_d   = imm1_q;
        imm2_d   = imm2_q;
        imm3_d   = imm3_q;
        if (bus.i_flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: bus.i_instruction, addr: bus.i_instruction_address};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (load) begin
                valid_d = 1'b1;
                code_d  = dec_code;
                addr_d  = head.addr;
                imm1_d  = opnd1;
                imm2_d  = opnd2;
                imm3_d  = dec_imm3;
            end else if (bus.i_out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            code_q   <= INSTR_CODE_INVALID;
            addr_q   <= '0;
            imm1_q   <= '0;
            imm2_q   <= '0;
            imm3_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            addr_q   <= addr_d;
            imm1_q   <= imm1_d;
            imm2_q   <= imm2_d;
            imm3_q   <= imm3_d;
        end
    end

    assign bus.o_ready               = !full || bus.i_flush;
    assign bus.o_read_gpr_A_sel      = sel_a;
    assign bus.o_read_gpr_B_sel      = sel_b;
    assign bus.o_valid               = valid_q;
    assign bus.o_decoded_instruction = code_q;
    assign bus.o_instruction_address = addr_q;
    assign bus.o_imm_1               = imm1_q;
    assign bus.o_imm_2               = imm2_q;
    assign bus.o_imm_3_or_dest_addr  = imm3_q;
    assign bus.o_count               = count_q;
endmodule
